noc_phase_sequencer: RTL and testbench

- Central simulation-cycle controller for the NoC router array.
- Broadcasts the per-cycle operation sequence LoadStaging -> Phase0 -> Phase1 to all routers and pulses the staging-interconnect load.
- Holds each phase until every router acknowledges it, counts simulated cycles, and terminates on cycle limit, network drain or abort.

---
 rtl/noc_phase_sequencer.sv | 160 ++++++++++++++++
 tb/tb_noc_phase_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_phase_sequencer.sv
// noc_phase_sequencer: per-cycle LoadStaging/Phase0/Phase1 sequencer for the NoC router array.
// Optional phase watchdog is built when NOC_PHASE_WATCHDOG_EN is defined.
module noc_phase_sequencer #(
  parameter int NUM_ROUTERS = 16,
  parameter int OP_W        = 2,
  parameter int CYC_W       = 16,
  parameter int WDOG_W      = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   stop_on_drain,
  input  logic [CYC_W-1:0]       max_cycles,
  input  logic [NUM_ROUTERS-1:0] phase_ack,
  input  logic [NUM_ROUTERS-1:0] done_vec,
  output logic [OP_W-1:0]        op,
  output logic                   stage_load,
  output logic [CYC_W-1:0]       in_cycle,
  output logic                   busy,
  output logic                   finished,
  output logic                   timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_P0, S_P1, S_FINISH
  } state_t;

  localparam logic [OP_W-1:0] OP_NOP  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_LOAD = OP_W'(1);
  localparam logic [OP_W-1:0] OP_P0   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_P1   = OP_W'(3);

  state_t           state, state_n;
  logic [OP_W-1:0]  op_n;
  logic [CYC_W-1:0] limit;
  logic [CYC_W-1:0] cyc_inc;
  logic             first;
  logic             armed;
  logic             abort_pend;
  logic             all_ack;
  logic             all_done;
  logic             adv;
  logic             active;
  logic             accept;
  logic             entering;
  logic             wd_fire;

  assign all_ack  = &phase_ack;
  assign all_done = &done_vec;
  assign adv      = all_ack & ~first;
  assign active   = (state == S_LOAD) || (state == S_P0) || (state == S_P1);
  assign accept   = start & armed & ((state == S_IDLE) || (state == S_FINISH));
  assign cyc_inc  = (&in_cycle) ? in_cycle : in_cycle + 1'b1;
  assign entering = (state_n != state);

`ifdef NOC_PHASE_WATCHDOG_EN
  logic [WDOG_W-1:0] wdog;

  assign wd_fire = active & (&wdog);

  // Watchdog: restart on each state entry, count cycles waiting for ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog    <= '0;
      timeout <= 1'b0;
    end else begin
      if (entering)
        wdog <= '0;
      else if (active && !all_ack)
        wdog <= wdog + 1'b1;
      if (accept)
        timeout <= 1'b0;
      else if (wd_fire)
        timeout <= 1'b1;
    end
  end
`else
  assign wd_fire = 1'b0 && (WDOG_W > 0);
  assign timeout = 1'b0;
`endif

  // Next-state and next-op decode
  always_comb begin
    state_n = state;
    op_n    = OP_NOP;
    unique case (state)
      S_IDLE, S_FINISH: begin
        if (accept)
          state_n = (max_cycles == '0) ? S_FINISH : S_LOAD;
      end
      S_LOAD: begin
        if (wd_fire)  state_n = S_FINISH;
        else if (adv) state_n = S_P0;
      end
      S_P0: begin
        if (wd_fire)  state_n = S_FINISH;
        else if (adv) state_n = S_P1;
      end
      S_P1: begin
        if (wd_fire)
          state_n = S_FINISH;
        else if (adv) begin
          if (abort || abort_pend)
            state_n = S_FINISH;
          else if (cyc_inc == limit)
            state_n = S_FINISH;
          else if (stop_on_drain && all_done)
            state_n = S_FINISH;
          else
            state_n = S_LOAD;
        end
      end
      default: state_n = S_IDLE;
    endcase
    unique case (state_n)
      S_LOAD:  op_n = OP_LOAD;
      S_P0:    op_n = OP_P0;
      S_P1:    op_n = OP_P1;
      default: op_n = OP_NOP;
    endcase
  end

  // State, registered outputs, cycle counter and pending abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      first      <= 1'b0;
      armed      <= 1'b0;
      abort_pend <= 1'b0;
      limit      <= '0;
      in_cycle   <= '0;
      op         <= OP_NOP;
      stage_load <= 1'b0;
      busy       <= 1'b0;
      finished   <= 1'b0;
    end else begin
      armed      <= 1'b1;
      state      <= state_n;
      first      <= entering;
      op         <= op_n;
      stage_load <= entering &&
                    ((state_n == S_LOAD) || (state_n == S_P1));
      busy       <= (state_n == S_LOAD) || (state_n == S_P0) ||
                    (state_n == S_P1);
      finished   <= (state_n == S_FINISH);
      if (accept) begin
        limit      <= max_cycles;
        in_cycle   <= '0;
        abort_pend <= 1'b0;
      end else begin
        if (state == S_P1 && adv && !wd_fire)
          in_cycle <= cyc_inc;
        if (abort && active)
          abort_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_noc_phase_sequencer.sv
// tb_noc_phase_sequencer: randomized runs checked against a
// run-level model (expected op list, cycle count, load pulses).
module tb_noc_phase_sequencer;

  localparam int NR = 16;
  localparam int CW = 16;
  localparam int NEVER = 1 << 30;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          stop_on_drain = 1'b0;
  logic [CW-1:0] max_cycles = '0;
  logic [NR-1:0] phase_ack = '0;
  logic [NR-1:0] done_vec = '0;
  logic [1:0]    op;
  logic          stage_load;
  logic [CW-1:0] in_cycle;
  logic          busy;
  logic          finished;
  logic          timeout;

  int n_chk = 0;
  int n_fail = 0;

  int ack_dly = -1;
  bit hold5 = 1'b0;
  int drain_at = NEVER;
  int abort_at = -1;
  bit abort_done = 1'b0;

  logic [1:0] ops[$];
  logic [1:0] prev_op = 2'd0;
  int ld_cnt = 0;
  int dwell = 0;
  int dwell_viol = 0;
  int cyc_viol = 0;
  int n3 = 0;
  int ack_cnt = 0;

  noc_phase_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .stop_on_drain(stop_on_drain), .max_cycles(max_cycles),
    .phase_ack(phase_ack), .done_vec(done_vec), .op(op),
    .stage_load(stage_load), .in_cycle(in_cycle), .busy(busy),
    .finished(finished), .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [NR-1:0] partial();
    logic [NR-1:0] v;
    v = NR'($urandom);
    v[$urandom_range(0, NR-1)] = 1'b0;
    return v;
  endfunction

  // Monitor and router responder, just after each rising edge
  always @(posedge clk) begin
    #1;
    if (stage_load) ld_cnt++;
    if (op != prev_op) begin
      if (prev_op != 2'd0 && dwell < 2) dwell_viol++;
      if (op != 2'd0) ops.push_back(op);
      if (op == 2'd1 && int'(in_cycle) != n3) cyc_viol++;
      if (op == 2'd3) n3++;
      dwell = 1;
      prev_op = op;
      ack_cnt = (ack_dly < 0) ? $urandom_range(0, 3) : ack_dly;
    end else begin
      dwell++;
      if (ack_cnt > 0) ack_cnt--;
    end
    phase_ack = partial();
    if (op != 2'd0 && ack_cnt == 0) phase_ack = '1;
    if (hold5) phase_ack[5] = 1'b0;
    done_vec = (int'(in_cycle) >= drain_at) ? '1 : partial();
    abort = 1'b0;
    if (abort_at >= 0 && !abort_done && op == 2'd2 &&
        int'(in_cycle) == abort_at) begin
      abort = 1'b1;
      abort_done = 1'b1;
    end
  end

  task automatic clear_mon();
    ops.delete();
    ld_cnt = 0;
    dwell = 0;
    dwell_viol = 0;
    cyc_viol = 0;
    n3 = 0;
    prev_op = op;
  endtask

  task automatic do_run(input string name, input int lim,
                        input bit stop, input int d,
                        input int a, input int dly);
    int n;
    int bound;
    int k;
    int bad;
    @(negedge clk);
    max_cycles = CW'(lim);
    stop_on_drain = stop;
    drain_at = d;
    abort_at = a;
    abort_done = 1'b0;
    ack_dly = dly;
    clear_mon();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    max_cycles = CW'($urandom);
    n = lim;
    if (stop && d + 1 < n) n = d + 1;
    if (a >= 0 && a + 1 < n) n = a + 1;
    bound = 20 * n + 40;
    k = 0;
    while (!finished && k < bound) begin
      @(negedge clk);
      k++;
      if (k == 8 && busy) begin
        start = 1'b1;
        max_cycles = CW'(1);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    n_chk++;
    if (finished !== 1'b1) begin
      n_fail++;
      $display("FAIL %s finish_wait: finished=%b after %0d cycles, need 1",
               name, finished, k);
    end
    n_chk++;
    if (int'(in_cycle) != n) begin
      n_fail++;
      $display("FAIL %s in_cycle: got %0d need %0d", name, in_cycle, n);
    end
    n_chk++;
    if (ld_cnt != 2 * n) begin
      n_fail++;
      $display("FAIL %s stage_load_count: got %0d need %0d",
               name, ld_cnt, 2 * n);
    end
    bad = 0;
    foreach (ops[i]) if (ops[i] != 2'((i % 3) + 1)) bad++;
    n_chk++;
    if (ops.size() != 3 * n || bad != 0) begin
      n_fail++;
      $display("FAIL %s op_sequence: got %0d ops (%0d misplaced) need %0d",
               name, ops.size(), bad, 3 * n);
    end
    n_chk++;
    if (dwell_viol != 0 || cyc_viol != 0) begin
      n_fail++;
      $display("FAIL %s dwell_cycle: got %0d short/%0d bad-count need 0/0",
               name, dwell_viol, cyc_viol);
    end
    n_chk++;
    if (busy !== 1'b0 || op !== 2'd0 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL %s end_state: got busy=%b op=%0d timeout=%b need 0/0/0",
               name, busy, op, timeout);
    end
  endtask

  task automatic test_reset();
    #12;
    n_chk++;
    if (op !== 2'd0 || stage_load !== 1'b0 || in_cycle !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got op=%0d sl=%b cyc=%0d need 0/0/0",
               op, stage_load, in_cycle);
    end
    n_chk++;
    if (busy !== 1'b0 || finished !== 1'b0 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got busy=%b fin=%b to=%b need 0/0/0",
               busy, finished, timeout);
    end
    @(negedge clk);
    max_cycles = CW'(3);
    start = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || op !== 2'd0 || finished !== 1'b0) begin
      n_fail++;
      $display("FAIL start_at_reset_release: got busy=%b op=%0d fin=%b need 0/0/0",
               busy, op, finished);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    @(negedge clk);
    max_cycles = CW'(20);
    stop_on_drain = 1'b0;
    drain_at = NEVER;
    abort_at = -1;
    ack_dly = -1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!(op == 2'd3 && in_cycle == CW'(7)) && k < 400) begin
      @(negedge clk);
      k++;
    end
    n_chk++;
    if (op !== 2'd3 || in_cycle !== CW'(7)) begin
      n_fail++;
      $display("FAIL reach_cycle7_p1: got op=%0d cyc=%0d need 3/7",
               op, in_cycle);
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (op !== 2'd0 || in_cycle !== '0 || busy !== 1'b0 ||
        stage_load !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got op=%0d cyc=%0d busy=%b sl=%b need 0/0/0/0",
               op, in_cycle, busy, stage_load);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_run("after_reset", 3, 1'b0, NEVER, -1, -1);
  endtask

  task automatic test_no_watchdog();
    @(negedge clk);
    hold5 = 1'b1;
    ack_dly = 0;
    max_cycles = CW'(5);
    stop_on_drain = 1'b0;
    abort_at = -1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    n_chk++;
    if (op !== 2'd1 || busy !== 1'b1 || timeout !== 1'b0 ||
        finished !== 1'b0) begin
      n_fail++;
      $display("FAIL stuck_in_load: got op=%0d busy=%b to=%b fin=%b need 1/1/0/0",
               op, busy, timeout, finished);
    end
    hold5 = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int lim;
    bit stop;
    int d;
    int a;
    for (int i = 0; i < 5; i++) begin
      lim = $urandom_range(1, 8);
      stop = 1'($urandom);
      d = $urandom_range(0, 9);
      a = int'($urandom_range(0, 10)) - 1;
      do_run("random", lim, stop, d, a, -1);
    end
  endtask

  initial begin
    test_reset();
    do_run("basic", 3, 1'b0, 0, -1, 2);
    do_run("drain", 100, 1'b1, 4, -1, -1);
    do_run("stale_ack", 4, 1'b0, NEVER, -1, 0);
    do_run("abort", 10, 1'b0, NEVER, 2, -1);
    do_run("zero_limit", 0, 1'b0, NEVER, -1, -1);
    test_random();
    test_reset_mid();
    test_no_watchdog();
    do_run("final", 2, 1'b0, NEVER, -1, -1);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
